mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory port between two masters.

---
 rtl/mem_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single unified instruction/data memory port between two
//   masters: master 0 is the multicycle CPU (fetch/load/store), master 1 is
//   the debug/program loader. A registered IDLE -> ISSUE -> RESP FSM performs
//   round-robin arbitration with an optional bus lock for atomic sequences,
//   and waits for a variable-latency memory that completes with mem_ack.
//
// Configuration macro:
//   MEM_ARB_TIMEOUT_EN  when defined, an 8-bit ISSUE-cycle counter aborts a
//                       transfer after TIMEOUT_CYCLES cycles without mem_ack
//                       (ack + err pulse, rdata 0, lock dropped). When
//                       undefined, ISSUE waits indefinitely and mN_err is 0.
//
// Ports:
//   clk, rstn            clock (rising edge), synchronous active-low reset
//   mN_req/we/lock       master N request (held until ack), write enable,
//                        keep-ownership request
//   mN_addr/mN_wdata     master N address and write data
//   mN_rdata/ack/err     read data (valid with ack), 1-cycle completion pulse,
//                        1-cycle abort pulse (with ack)
//   mem_req/we/addr/wdata memory request (held until mem_ack) and its payload
//   mem_rdata/mem_ack    memory read data and 1-cycle completion
// ----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic                  m0_lock,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_ack,
   output logic                  m0_err,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic                  m1_lock,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_ack,
   output logic                  m1_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t                state_r;
   logic                  last_r;   // last granted master; doubles as current owner / lock holder
   logic                  lock_r;   // bus locked to last_r

   logic                  own_req_s;
   logic                  own_lock_s;
   logic                  gnt_valid_s;
   logic                  gnt_id_s;
   logic                  lock_rel_s;
   logic                  sel_we_s;
   logic                  sel_lock_s;
   logic [ADDR_WIDTH-1:0] sel_addr_s;
   logic [DATA_WIDTH-1:0] sel_wdata_s;
   logic                  tmo_hit_s;

   // Request and lock inputs of the current owner, consulted while locked
   always_comb begin
      own_req_s  = 1'b0;
      own_lock_s = 1'b0;
      if (last_r) begin
         own_req_s  = m1_req;
         own_lock_s = m1_lock;
      end else begin
         own_req_s  = m0_req;
         own_lock_s = m0_lock;
      end
   end

   // Arbitration: locked bus serves only its owner, otherwise round robin on ties
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
      lock_rel_s  = 1'b0;
      if (lock_r) begin
         gnt_id_s = last_r;
         if (own_req_s) begin
            gnt_valid_s = 1'b1;
         end else if (!own_lock_s) begin
            // owner idle and no longer asking for the lock: release it
            lock_rel_s = 1'b1;
         end else begin
            lock_rel_s = 1'b0;
         end
      end else begin
         case ({m1_req, m0_req})
            2'b01: begin
               gnt_valid_s = 1'b1;
               gnt_id_s    = 1'b0;
            end
            2'b10: begin
               gnt_valid_s = 1'b1;
               gnt_id_s    = 1'b1;
            end
            2'b11: begin
               gnt_valid_s = 1'b1;
               gnt_id_s    = ~last_r;
            end
            default: begin
               gnt_valid_s = 1'b0;
               gnt_id_s    = 1'b0;
            end
         endcase
      end
   end

   // Transfer payload of the master being granted
   always_comb begin
      sel_we_s    = 1'b0;
      sel_lock_s  = 1'b0;
      sel_addr_s  = '0;
      sel_wdata_s = '0;
      if (gnt_id_s) begin
         sel_we_s    = m1_we;
         sel_lock_s  = m1_lock;
         sel_addr_s  = m1_addr;
         sel_wdata_s = m1_wdata;
      end else begin
         sel_we_s    = m0_we;
         sel_lock_s  = m0_lock;
         sel_addr_s  = m0_addr;
         sel_wdata_s = m0_wdata;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt_r;

   // ISSUE-cycle counter: restarted at every grant, advanced while memory is silent
   always_ff @(posedge clk) begin
      if (!rstn) begin
         tmo_cnt_r <= 8'd0;
      end else if ((state_r == ST_IDLE) && gnt_valid_s) begin
         tmo_cnt_r <= 8'd0;
      end else if ((state_r == ST_ISSUE) && !mem_ack) begin
         tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   // Fires on the last permitted ISSUE cycle so mem_req stays up exactly TIMEOUT_CYCLES cycles
   assign tmo_hit_s = (state_r == ST_ISSUE) && !mem_ack && (tmo_cnt_r == TMO_LAST);
`else
   assign tmo_hit_s = 1'b0;
`endif

   // Main FSM with all master/memory outputs registered
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r   <= ST_IDLE;
         last_r    <= 1'b1;
         lock_r    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         m0_ack    <= 1'b0;
         m0_err    <= 1'b0;
         m0_rdata  <= '0;
         m1_ack    <= 1'b0;
         m1_err    <= 1'b0;
         m1_rdata  <= '0;
      end else begin
         // response outputs are pulses; only the ISSUE exit below raises them
         m0_ack   <= 1'b0;
         m0_err   <= 1'b0;
         m0_rdata <= '0;
         m1_ack   <= 1'b0;
         m1_err   <= 1'b0;
         m1_rdata <= '0;
         case (state_r)
            ST_IDLE: begin
               if (gnt_valid_s) begin
                  last_r    <= gnt_id_s;
                  lock_r    <= sel_lock_s;
                  mem_we    <= sel_we_s;
                  mem_addr  <= sel_addr_s;
                  mem_wdata <= sel_wdata_s;
                  mem_req   <= 1'b1;
                  state_r   <= ST_ISSUE;
               end else begin
                  lock_r  <= lock_r & ~lock_rel_s;
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (mem_ack) begin
                  // completion wins over a timeout in the same cycle
                  mem_req <= 1'b0;
                  state_r <= ST_RESP;
                  if (last_r) begin
                     m1_ack   <= 1'b1;
                     m1_rdata <= mem_rdata;
                  end else begin
                     m0_ack   <= 1'b1;
                     m0_rdata <= mem_rdata;
                  end
               end else if (tmo_hit_s) begin
                  mem_req <= 1'b0;
                  lock_r  <= 1'b0;
                  state_r <= ST_RESP;
                  if (last_r) begin
                     m1_ack <= 1'b1;
                     m1_err <= 1'b1;
                  end else begin
                     m0_ack <= 1'b1;
                     m0_err <= 1'b1;
                  end
               end else begin
                  state_r <= ST_ISSUE;
               end
            end
            ST_RESP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A transaction-level reference model
//   (grant rules, ownership, lock, response due) predicts every cycle's
//   outputs; a compare process checks them on each falling edge. Directed
//   scenarios add hand-computed literal expectations (grant order, latency,
//   read data, reset behaviour, timeout, write payload).
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TMO    = 4;
   localparam bit TMO_EN = 1'b1;
`else
   localparam int TMO    = 255;
   localparam bit TMO_EN = 1'b0;
`endif

   typedef struct packed {
      logic          we;
      logic          lock;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   typedef struct packed {
      int            owner;
      logic          err;
      logic [DW-1:0] rdata;
      int            cyc;
   } ack_t;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic          m_req   [2];
   logic          m_we    [2];
   logic          m_lock  [2];
   logic [AW-1:0] m_addr  [2];
   logic [DW-1:0] m_wdata [2];
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          m0_ack, m1_ack, m0_err, m1_err;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = 32'h0;
   logic          mem_ack   = 1'b0;

   logic          ack_v   [2];
   logic          err_v   [2];
   logic [DW-1:0] rdata_v [2];
   assign ack_v[0]   = m0_ack;
   assign ack_v[1]   = m1_ack;
   assign err_v[0]   = m0_err;
   assign err_v[1]   = m1_err;
   assign rdata_v[0] = m0_rdata;
   assign rdata_v[1] = m1_rdata;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rstn(rstn),
      .m0_req(m_req[0]), .m0_we(m_we[0]), .m0_lock(m_lock[0]),
      .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]),
      .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_req(m_req[1]), .m1_we(m_we[1]), .m1_lock(m_lock[1]),
      .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]),
      .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- bench memory ----------------
   logic [DW-1:0] mem_arr [logic [AW-1:0]];
   int            lat  = 0;   // wait cycles after mem_req rises; -1 = never answer
   int            wcnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            wcnt      = 0;
         end else if (mem_req && rstn) begin
            if (lat >= 0 && wcnt >= lat) begin
               mem_ack = 1'b1;
               if (mem_we) begin
                  mem_arr[mem_addr] = mem_wdata;
                  mem_rdata = $urandom;
               end else begin
                  mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : ~mem_addr;
               end
            end else begin
               wcnt++;
               mem_rdata = $urandom;
            end
         end else begin
            wcnt      = 0;
            mem_rdata = $urandom;
         end
      end
   end

   // ---------------- master drivers ----------------
   txn_t q0[$];
   txn_t q1[$];
   bit   pres [2];

   initial begin
      txn_t t;
      bit   have;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (pres[i] && ack_v[i]) begin
               pres[i] = 1'b0;
               if (i == 0) void'(q0.pop_front());
               else        void'(q1.pop_front());
            end
            have = 1'b0;
            if (i == 0 && q0.size() > 0) begin
               have = 1'b1;
               t    = q0[0];
            end else if (i == 1 && q1.size() > 0) begin
               have = 1'b1;
               t    = q1[0];
            end
            if (!pres[i] && have) begin
               m_req[i]   = 1'b1;
               m_we[i]    = t.we;
               m_lock[i]  = t.lock;
               m_addr[i]  = t.addr;
               m_wdata[i] = t.wdata;
               pres[i]    = 1'b1;
            end else if (!pres[i]) begin
               m_req[i]   = 1'b0;
               m_lock[i]  = 1'b0;
               m_we[i]    = 1'b0;
               m_addr[i]  = $urandom;
               m_wdata[i] = $urandom;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   bit            x_act, a_due, a_err, locked;
   int            x_own, x_len, last_g, mg;
   logic          x_we;
   logic [AW-1:0] x_addr;
   logic [DW-1:0] x_wdata, a_data;
   bit            e_mem_req;

   task automatic model_step();
      if (!rstn) begin
         x_act = 0; a_due = 0; last_g = 1; locked = 0;
         x_we = 1'b0; x_addr = '0; x_wdata = '0;
      end else if (a_due) begin
         a_due = 0;                         // response cycle; requests ignored
      end else if (x_act) begin
         x_len++;
         if (mem_ack) begin
            a_due = 1; a_err = 0; a_data = mem_rdata; x_act = 0;
         end else if (TMO_EN && x_len == TMO) begin
            a_due = 1; a_err = 1; a_data = '0; x_act = 0; locked = 0;
         end
      end else begin
         mg = -1;
         if (locked) begin
            if (m_req[last_g]) mg = last_g;
            else if (!m_lock[last_g]) locked = 0;
         end else if (m_req[0] && m_req[1]) mg = 1 - last_g;
         else if (m_req[0]) mg = 0;
         else if (m_req[1]) mg = 1;
         if (mg >= 0) begin
            x_act = 1; x_len = 0; x_own = mg; last_g = mg;
            locked = m_lock[mg]; x_we = m_we[mg];
            x_addr = m_addr[mg]; x_wdata = m_wdata[mg];
         end
      end
      e_mem_req = x_act;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         model_step();
      end
   end

   // ---------------- compare process ----------------
   ack_t ack_log[$];
   int   rise_cyc = 0;
   int   run      = 0;
   int   last_run = 0;
   bit   prev_req = 0;

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("mem_req", 32'(mem_req), 32'(e_mem_req));
         if (e_mem_req) begin
            chk("mem_addr", mem_addr, x_addr);
            chk("mem_we", 32'(mem_we), 32'(x_we));
            chk("mem_wdata", mem_wdata, x_wdata);
         end
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d_ack", i), 32'(ack_v[i]), 32'(a_due && x_own == i));
            chk($sformatf("m%0d_err", i), 32'(err_v[i]), 32'(a_due && x_own == i && a_err));
            if (a_due)
               chk($sformatf("m%0d_rdata", i), rdata_v[i], (x_own == i) ? a_data : 32'h0);
            if (ack_v[i]) ack_log.push_back('{owner: i, err: err_v[i], rdata: rdata_v[i], cyc: cyc});
         end
         if (mem_req && !prev_req) rise_cyc = cyc;
         if (mem_req) run++;
         else if (run > 0) begin
            last_run = run;
            run      = 0;
         end
         prev_req = mem_req;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input int i, input logic we, input logic lock,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      txn_t t;
      t = '{we: we, lock: lock, addr: addr, wdata: wdata};
      if (i == 0) q0.push_back(t);
      else        q1.push_back(t);
   endtask

   task automatic wait_acks(input int n, input int budget, input string nm);
      int k = 0;
      while (ack_log.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (ack_log.size() < n) begin
         n_errors++;
         $display("FAIL %s: timeout, got %0d acks, expected %0d", nm, ack_log.size(), n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_mem_req(input int budget, input string nm);
      int k = 0;
      while (!mem_req && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (!mem_req) begin
         n_errors++;
         $display("FAIL %s: timeout waiting for mem_req, got 0, expected 1", nm);
      end
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         pres[i]  = 1'b0;
         m_req[i] = 1'b0;
         m_lock[i] = 1'b0;
      end
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      for (int i = 0; i < 2; i++) begin
         m_req[i] = 1'b0; m_we[i] = 1'b0; m_lock[i] = 1'b0;
         m_addr[i] = '0;  m_wdata[i] = '0; pres[i] = 1'b0;
      end
      @(negedge clk);
      // reset state
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_acks", 32'({m1_ack, m0_ack, m1_err, m0_err}), 32'h0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      // 1: single read, memory answers 2 cycles after mem_req
      ack_log.delete();
      lat = 2;
      mem_arr[32'h100] = 32'hDEADBEEF;
      push(0, 1'b0, 1'b0, 32'h100, 32'h0);
      wait_mem_req(20, "t1_req");
      chk("t1_addr", mem_addr, 32'h100);
      chk("t1_we", 32'(mem_we), 32'h0);
      wait_acks(1, 30, "t1_ack");
      chk("t1_nacks", 32'(ack_log.size()), 32'd1);
      if (ack_log.size() > 0) begin
         chk("t1_owner", 32'(ack_log[0].owner), 32'd0);
         chk("t1_rdata", ack_log[0].rdata, 32'hDEADBEEF);
         chk("t1_latency", 32'(ack_log[0].cyc - rise_cyc), 32'd3);
      end

      // 2: ties after reset, zero-wait memory -> m0,m1,m0,m1, one IDLE+ISSUE+RESP each
      apply_reset();
      @(negedge clk);
      rstn = 1'b1;
      ack_log.delete();
      lat = 0;
      push(0, 1'b0, 1'b0, 32'h200, 32'h0);
      push(0, 1'b1, 1'b0, 32'h204, 32'hA0A0_0001);
      push(1, 1'b1, 1'b0, 32'h300, 32'hB0B0_0002);
      push(1, 1'b0, 1'b0, 32'h304, 32'h0);
      wait_acks(4, 60, "t2_ack");
      if (ack_log.size() == 4) begin
         chk("t2_order0", 32'(ack_log[0].owner), 32'd0);
         chk("t2_order1", 32'(ack_log[1].owner), 32'd1);
         chk("t2_order2", 32'(ack_log[2].owner), 32'd0);
         chk("t2_order3", 32'(ack_log[3].owner), 32'd1);
         for (int k = 1; k < 4; k++)
            chk($sformatf("t2_spacing%0d", k), 32'(ack_log[k].cyc - ack_log[k-1].cyc), 32'd3);
      end

      // 3: m1 locked write then unlocked read while m0 keeps requesting
      ack_log.delete();
      lat = 1;
      push(1, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
      push(1, 1'b0, 1'b0, 32'h20, 32'h0);
      wait_mem_req(20, "t3_req");
      push(0, 1'b0, 1'b0, 32'h30, 32'h0);
      wait_acks(3, 60, "t3_ack");
      if (ack_log.size() == 3) begin
         chk("t3_order0", 32'(ack_log[0].owner), 32'd1);
         chk("t3_order1", 32'(ack_log[1].owner), 32'd1);
         chk("t3_order2", 32'(ack_log[2].owner), 32'd0);
         chk("t3_rdback", ack_log[1].rdata, 32'hCAFEF00D);
      end

      // 4: reset for one cycle while mem_req is high
      ack_log.delete();
      lat = -1;
      push(0, 1'b0, 1'b0, 32'h400, 32'h0);
      wait_mem_req(20, "t4_req");
      apply_reset();
      @(negedge clk);
      chk("t4_mem_req", 32'(mem_req), 32'h0);
      chk("t4_acks", 32'({m1_ack, m0_ack}), 32'h0);
      rstn = 1'b1;
      lat  = 0;
      push(0, 1'b0, 1'b0, 32'h404, 32'h0);
      push(1, 1'b0, 1'b0, 32'h408, 32'h0);
      wait_acks(2, 40, "t4_ack");
      if (ack_log.size() == 2) begin
         chk("t4_first", 32'(ack_log[0].owner), 32'd0);
         chk("t4_second", 32'(ack_log[1].owner), 32'd1);
      end

`ifdef MEM_ARB_TIMEOUT_EN
      // 5: memory never answers -> abort after 4 ISSUE cycles
      ack_log.delete();
      lat = -1;
      push(0, 1'b0, 1'b0, 32'h500, 32'h0);
      wait_acks(1, 40, "t5_ack");
      if (ack_log.size() > 0) begin
         chk("t5_owner", 32'(ack_log[0].owner), 32'd0);
         chk("t5_err", 32'(ack_log[0].err), 32'd1);
         chk("t5_rdata", ack_log[0].rdata, 32'h0);
         chk("t5_req_len", 32'(last_run), 32'd4);
      end
`endif

      // 6: write with 3 wait cycles (coincides with the timeout edge when enabled)
      ack_log.delete();
      lat = 3;
      push(0, 1'b1, 1'b0, 32'h44, 32'h12345678);
      wait_acks(1, 40, "t6_ack");
      if (ack_log.size() > 0) begin
         chk("t6_owner", 32'(ack_log[0].owner), 32'd0);
         chk("t6_err", 32'(ack_log[0].err), 32'd0);
      end
      chk("t6_store", mem_arr.exists(32'h44) ? mem_arr[32'h44] : 32'h0, 32'h12345678);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
